// File: rtl/uart_byte_tx.sv
// 8N1 byte-wide serial transmitter with valid/ready intake and registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
`timescale 1ns/1ps

module uart_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic        IDLE_LEVEL   = 1'b1
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    always_comb begin
        bit_end = (baud_q == BAUD_LAST);
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tx_valid && ready_q) begin
                        shift_q <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^tx_data;
`endif
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                S_START: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        // tx is registered, so the next bit is taken from shift_q[1] before the shift lands
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            bit_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= IDLE_LEVEL;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= S_STOP;
                        tx_q    <= IDLE_LEVEL;
                    end
                end
`endif
                S_STOP: begin
                    baud_q <= baud_d;
                    // done is registered, so it is raised one count early to land in the last stop cycle
                    done_q <= (baud_q == BAUD_PRE);
                    if (bit_end) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= IDLE_LEVEL;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = ready_q;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
